// File: rtl/spike_pkg.sv
// Shared types and constants for the spike detection chain.
package spike_pkg;

    localparam int SAMPLE_W = 16;
    localparam int LEN_W    = 8;
    localparam int TS_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        REFRACT
    } state_t;

    // Event record at the default timestamp width.
    typedef struct packed {
        logic [TS_W_DEF-1:0]        timestamp;
        logic signed [SAMPLE_W-1:0] peak;
        logic [LEN_W-1:0]           len;
    } spike_evt_t;

    // Unsigned magnitude, one bit wider so that -32768 maps to 32768.
    function automatic logic [SAMPLE_W:0] sample_mag(input logic [SAMPLE_W-1:0] s);
        logic [SAMPLE_W:0] ext;
        ext = {s[SAMPLE_W-1], s};
        return s[SAMPLE_W-1] ? (~ext + (SAMPLE_W+1)'(1)) : ext;
    endfunction

endpackage

// File: rtl/event_fifo.sv
// First-word-fall-through FIFO; head word is visible while not empty.
module event_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign count   = count_reg;
    assign do_pop  = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = wr_en && (!full || do_pop);

    // Storage array, no reset so it can map onto distributed/block memory.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Head word is forced to zero when empty so stale entries never leak out.
    assign rd_data = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/spike_event_framer.sv
// Groups per-sample spike flags into events (onset, peak, length),
// applies a refractory window and queues events for readout.
module spike_event_framer
    import spike_pkg::*;
#(
    parameter int TS_W        = 32,
    parameter int ALIGN_DELAY = 4,
    parameter int MAX_LEN     = 64,
    parameter int REFRACTORY  = 16,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                spike_in,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [TS_W-1:0]     evt_timestamp,
    output logic [SAMPLE_W-1:0] evt_peak,
    output logic [LEN_W-1:0]    evt_len,
    output logic [15:0]         drop_cnt,
    output logic                busy
);

    localparam int REF_W = (REFRACTORY > 0) ? $clog2(REFRACTORY + 1) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [TS_W-1:0]     timestamp;
        logic [SAMPLE_W-1:0] peak;
        logic [LEN_W-1:0]    len;
    } evt_t;

    logic [SAMPLE_W-1:0] aligned;

    generate
        if (ALIGN_DELAY == 0) begin : g_no_delay
            assign aligned = sample_in;
        end else begin : g_delay
            logic [SAMPLE_W-1:0] dly_reg [ALIGN_DELAY];
            // Strobe-driven delay line matching the detector latency.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < ALIGN_DELAY; i++) begin
                        dly_reg[i] <= '0;
                    end
                end else if (sample_valid) begin
                    dly_reg[0] <= sample_in;
                    for (int i = 1; i < ALIGN_DELAY; i++) begin
                        dly_reg[i] <= dly_reg[i-1];
                    end
                end
            end
            assign aligned = dly_reg[ALIGN_DELAY-1];
        end
    endgenerate

    state_t              state_reg, state_next;
    logic [TS_W-1:0]     ts_cnt_reg;
    logic [TS_W-1:0]     ts_cap_reg, ts_cap_next;
    logic [SAMPLE_W-1:0] peak_reg, peak_next, peak_upd;
    logic [LEN_W-1:0]    len_reg, len_next;
    logic [REF_W-1:0]    refr_reg, refr_next;
    logic [15:0]         drop_cnt_reg;
    logic                busy_reg;
    logic                push;
    logic                pop;
    logic                accept;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    unused_fifo_count;
    evt_t                wr_evt;
    evt_t                rd_evt;

    // Strictly greater magnitude replaces the peak, so ties keep the earlier sample.
    assign peak_upd = (sample_mag(aligned) > sample_mag(peak_reg)) ? aligned : peak_reg;

    // Next-state and event-close decode; everything holds without a strobe.
    always_comb begin
        state_next  = state_reg;
        ts_cap_next = ts_cap_reg;
        peak_next   = peak_reg;
        len_next    = len_reg;
        refr_next   = refr_reg;
        push        = 1'b0;
        if (sample_valid) begin
            case (state_reg)
                IDLE: begin
                    if (spike_in) begin
                        ts_cap_next = ts_cnt_reg;
                        peak_next   = aligned;
                        len_next    = LEN_W'(1);
                        state_next  = ACTIVE;
                    end
                end
                ACTIVE: begin
                    peak_next = peak_upd;
                    if (spike_in && (len_reg < LEN_W'(MAX_LEN))) begin
                        len_next = len_reg + LEN_W'(1);
                    end else begin
                        push       = 1'b1;
                        refr_next  = REF_W'(REFRACTORY);
                        state_next = (REFRACTORY == 0) ? IDLE : REFRACT;
                    end
                end
                REFRACT: begin
                    refr_next = refr_reg - REF_W'(1);
                    if (refr_reg == REF_W'(1)) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // The closing strobe's sample is folded into the pushed peak.
    assign wr_evt.timestamp = ts_cap_reg;
    assign wr_evt.peak      = peak_upd;
    assign wr_evt.len       = len_reg;

    assign pop    = evt_valid && evt_ready;
    assign accept = !fifo_full || pop;

    // State, capture registers, strobe counter and drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            ts_cnt_reg   <= '0;
            ts_cap_reg   <= '0;
            peak_reg     <= '0;
            len_reg      <= '0;
            refr_reg     <= '0;
            drop_cnt_reg <= '0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg  <= state_next;
            ts_cap_reg <= ts_cap_next;
            peak_reg   <= peak_next;
            len_reg    <= len_next;
            refr_reg   <= refr_next;
            busy_reg   <= (state_next != IDLE);
            if (sample_valid) begin
                ts_cnt_reg <= ts_cnt_reg + TS_W'(1);
            end
            if (push && !accept && (drop_cnt_reg != 16'hFFFF)) begin
                drop_cnt_reg <= drop_cnt_reg + 16'd1;
            end
        end
    end

    event_fifo #(
        .WIDTH ($bits(evt_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push && accept),
        .wr_data (wr_evt),
        .rd_en   (pop),
        .rd_data (rd_evt),
        .count   (unused_fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign evt_valid     = !fifo_empty;
    assign evt_timestamp = rd_evt.timestamp;
    assign evt_peak      = rd_evt.peak;
    assign evt_len       = rd_evt.len;
    assign drop_cnt      = drop_cnt_reg;
    assign busy          = busy_reg;

endmodule

// File: tb/tb_spike_event_framer.sv
// Scoreboard bench for spike_event_framer (ALIGN_DELAY=0, REFRACTORY=4,
// MAX_LEN=64, FIFO_DEPTH=8).
module tb_spike_event_framer;
    import spike_pkg::*;

    localparam int TS_W = 32;

    logic                clk;
    logic                rst;
    logic                sample_valid;
    logic [SAMPLE_W-1:0] sample_in;
    logic                spike_in;
    logic                evt_valid;
    logic                evt_ready;
    logic [TS_W-1:0]     evt_timestamp;
    logic [SAMPLE_W-1:0] evt_peak;
    logic [LEN_W-1:0]    evt_len;
    logic [15:0]         drop_cnt;
    logic                busy;

    int         n_cmp = 0;
    int         n_err = 0;
    int         tb_ts = 0;
    spike_evt_t exp_q[$];
    spike_evt_t exp_e;
    spike_evt_t got_e;

    spike_event_framer #(
        .TS_W        (TS_W),
        .ALIGN_DELAY (0),
        .MAX_LEN     (64),
        .REFRACTORY  (4),
        .FIFO_DEPTH  (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sample_valid  (sample_valid),
        .sample_in     (sample_in),
        .spike_in      (spike_in),
        .evt_valid     (evt_valid),
        .evt_ready     (evt_ready),
        .evt_timestamp (evt_timestamp),
        .evt_peak      (evt_peak),
        .evt_len       (evt_len),
        .drop_cnt      (drop_cnt),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One sample strobe, launched and retired on falling edges.
    task automatic strobe(input logic spk, input int smp);
        sample_valid = 1'b1;
        spike_in     = spk;
        sample_in    = SAMPLE_W'(smp);
        @(negedge clk);
        sample_valid = 1'b0;
        spike_in     = 1'b0;
        sample_in    = '0;
        tb_ts++;
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) strobe(1'b0, 0);
    endtask

    task automatic expect_evt(input int ts, input int pk, input int ln);
        spike_evt_t e;
        e.timestamp = TS_W'(ts);
        e.peak      = SAMPLE_W'(pk);
        e.len       = LEN_W'(ln);
        exp_q.push_back(e);
    endtask

    task automatic apply_reset();
        rst = 1'b1; sample_valid = 1'b0; spike_in = 1'b0; sample_in = '0; evt_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tb_ts = 0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; sample_valid = 1'b0; spike_in = 1'b0; sample_in = '0; evt_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL reset_evt_valid got %b need 0", evt_valid); end
        n_cmp++; if (evt_timestamp !== '0) begin n_err++; $display("FAIL reset_ts got %0d need 0", evt_timestamp); end
        n_cmp++; if (evt_peak !== '0) begin n_err++; $display("FAIL reset_peak got %0d need 0", evt_peak); end
        n_cmp++; if (evt_len !== '0) begin n_err++; $display("FAIL reset_len got %0d need 0", evt_len); end
        n_cmp++; if (drop_cnt !== '0) begin n_err++; $display("FAIL reset_drop got %0d need 0", drop_cnt); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b need 0", busy); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        apply_reset();
        quiet(10);
        strobe(1'b1, 100);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy got %b need 1", busy); end
        strobe(1'b1, -300);
        strobe(1'b1, 200);
        n_cmp++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid got %b need 0", evt_valid); end
        strobe(1'b0, 0);
        expect_evt(10, -300, 3);
        n_cmp++; if (evt_valid !== 1'b1) begin n_err++; $display("FAIL basic_latency got %b need 1", evt_valid); end
        evt_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            if (evt_valid) begin
                exp_e = exp_q.pop_front();
                got_e = {evt_timestamp, evt_peak, evt_len};
                $display("basic evt ts=%0d peak=%0d len=%0d", got_e.timestamp, got_e.peak, got_e.len);
                n_cmp++;
                if (got_e !== exp_e) begin n_err++; $display("FAIL basic_evt got ts=%0d peak=%0d len=%0d need ts=%0d peak=%0d len=%0d", got_e.timestamp, got_e.peak, got_e.len, exp_e.timestamp, exp_e.peak, exp_e.len); end
            end
            @(negedge clk);
        end
        evt_ready = 1'b0;
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL basic_drain got %0d missing need 0", exp_q.size()); end
    endtask

    task automatic test_refractory();
        apply_reset();
        quiet(10);
        strobe(1'b1, 5);
        strobe(1'b1, -7);
        strobe(1'b0, 3);
        expect_evt(10, -7, 2);
        strobe(1'b0, 0);
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL refr_gap_busy got %b need 1", busy); end
        strobe(1'b1, 99);
        strobe(1'b0, 0);
        strobe(1'b0, 0);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL refr_end_busy got %b need 0", busy); end
        strobe(1'b1, 50);
        strobe(1'b0, 0);
        expect_evt(17, 50, 1);
        evt_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            if (evt_valid) begin
                exp_e = exp_q.pop_front();
                got_e = {evt_timestamp, evt_peak, evt_len};
                $display("refr evt ts=%0d peak=%0d len=%0d", got_e.timestamp, got_e.peak, got_e.len);
                n_cmp++;
                if (got_e !== exp_e) begin n_err++; $display("FAIL refr_evt got ts=%0d peak=%0d len=%0d need ts=%0d peak=%0d len=%0d", got_e.timestamp, got_e.peak, got_e.len, exp_e.timestamp, exp_e.peak, exp_e.len); end
            end
            @(negedge clk);
        end
        evt_ready = 1'b0;
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL refr_drain got %0d missing need 0", exp_q.size()); end
    endtask

    task automatic test_max_len();
        apply_reset();
        quiet(1);
        for (int i = 1; i <= 100; i++) strobe(1'b1, i);
        strobe(1'b0, 0);
        expect_evt(1, 65, 64);
        expect_evt(70, 100, 31);
        evt_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            if (evt_valid) begin
                exp_e = exp_q.pop_front();
                got_e = {evt_timestamp, evt_peak, evt_len};
                $display("maxlen evt ts=%0d peak=%0d len=%0d", got_e.timestamp, got_e.peak, got_e.len);
                n_cmp++;
                if (got_e !== exp_e) begin n_err++; $display("FAIL maxlen_evt got ts=%0d peak=%0d len=%0d need ts=%0d peak=%0d len=%0d", got_e.timestamp, got_e.peak, got_e.len, exp_e.timestamp, exp_e.peak, exp_e.len); end
            end
            @(negedge clk);
        end
        evt_ready = 1'b0;
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL maxlen_drain got %0d missing need 0", exp_q.size()); end
    endtask

    task automatic test_fifo_full();
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            strobe(1'b1, (i + 1) * 100);
            strobe(1'b0, 0);
            quiet(4);
            if (i < 8) expect_evt(6 * i, (i + 1) * 100, 1);
        end
        n_cmp++; if (drop_cnt !== 16'd2) begin n_err++; $display("FAIL full_drop got %0d need 2", drop_cnt); end
        evt_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp_e = exp_q.pop_front();
            got_e = {evt_timestamp, evt_peak, evt_len};
            $display("full evt ts=%0d peak=%0d len=%0d valid=%b", got_e.timestamp, got_e.peak, got_e.len, evt_valid);
            n_cmp++;
            if (!evt_valid || got_e !== exp_e) begin n_err++; $display("FAIL full_evt%0d got v=%b ts=%0d peak=%0d len=%0d need v=1 ts=%0d peak=%0d len=%0d", k, evt_valid, got_e.timestamp, got_e.peak, got_e.len, exp_e.timestamp, exp_e.peak, exp_e.len); end
            @(negedge clk);
        end
        evt_ready = 1'b0;
        n_cmp++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL full_empty got %b need 0", evt_valid); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            strobe(1'b1, (i + 1) * 100);
            strobe(1'b0, 0);
            quiet(4);
            expect_evt(6 * i, (i + 1) * 100, 1);
        end
        strobe(1'b1, 900);
        exp_e = exp_q.pop_front();
        got_e = {evt_timestamp, evt_peak, evt_len};
        $display("b2b evt ts=%0d peak=%0d len=%0d", got_e.timestamp, got_e.peak, got_e.len);
        n_cmp++;
        if (got_e !== exp_e) begin n_err++; $display("FAIL b2b_head got ts=%0d peak=%0d len=%0d need ts=%0d peak=%0d len=%0d", got_e.timestamp, got_e.peak, got_e.len, exp_e.timestamp, exp_e.peak, exp_e.len); end
        evt_ready = 1'b1;
        strobe(1'b0, 0);
        evt_ready = 1'b0;
        expect_evt(48, 900, 1);
        n_cmp++; if (drop_cnt !== 16'd0) begin n_err++; $display("FAIL b2b_drop got %0d need 0", drop_cnt); end
        evt_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp_e = exp_q.pop_front();
            got_e = {evt_timestamp, evt_peak, evt_len};
            $display("b2b evt ts=%0d peak=%0d len=%0d valid=%b", got_e.timestamp, got_e.peak, got_e.len, evt_valid);
            n_cmp++;
            if (!evt_valid || got_e !== exp_e) begin n_err++; $display("FAIL b2b_evt%0d got v=%b ts=%0d peak=%0d len=%0d need v=1 ts=%0d peak=%0d len=%0d", k, evt_valid, got_e.timestamp, got_e.peak, got_e.len, exp_e.timestamp, exp_e.peak, exp_e.len); end
            @(negedge clk);
        end
        evt_ready = 1'b0;
        n_cmp++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL b2b_count got valid=%b need 0", evt_valid); end
    endtask

    task automatic test_extremes_and_reset();
        apply_reset();
        strobe(1'b1, -32768);
        strobe(1'b1, 32767);
        strobe(1'b0, 0);
        expect_evt(0, -32768, 2);
        quiet(4);
        strobe(1'b1, 300);
        strobe(1'b1, -300);
        strobe(1'b0, 0);
        expect_evt(7, 300, 2);
        quiet(4);
        evt_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            if (evt_valid) begin
                exp_e = exp_q.pop_front();
                got_e = {evt_timestamp, evt_peak, evt_len};
                $display("ext evt ts=%0d peak=%0d len=%0d", got_e.timestamp, got_e.peak, got_e.len);
                n_cmp++;
                if (got_e !== exp_e) begin n_err++; $display("FAIL ext_evt got ts=%0d peak=%0d len=%0d need ts=%0d peak=%0d len=%0d", got_e.timestamp, got_e.peak, got_e.len, exp_e.timestamp, exp_e.peak, exp_e.len); end
            end
            @(negedge clk);
        end
        evt_ready = 1'b0;
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL ext_drain got %0d missing need 0", exp_q.size()); end
        // Leave one event queued and another open, then reset over both.
        strobe(1'b1, 9);
        strobe(1'b0, 0);
        quiet(4);
        strobe(1'b1, 5);
        strobe(1'b1, 6);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL midrst_busy_before got %b need 1", busy); end
        rst = 1'b1;
        #1;
        n_cmp++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL midrst_evt_valid got %b need 0", evt_valid); end
        n_cmp++; if (evt_timestamp !== '0) begin n_err++; $display("FAIL midrst_ts got %0d need 0", evt_timestamp); end
        n_cmp++; if (evt_peak !== '0) begin n_err++; $display("FAIL midrst_peak got %0d need 0", evt_peak); end
        n_cmp++; if (evt_len !== '0) begin n_err++; $display("FAIL midrst_len got %0d need 0", evt_len); end
        n_cmp++; if (drop_cnt !== '0) begin n_err++; $display("FAIL midrst_drop got %0d need 0", drop_cnt); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b need 0", busy); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tb_ts = 0;
        exp_q.delete();
        quiet(5);
        n_cmp++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL postrst_valid got %b need 0", evt_valid); end
        strobe(1'b1, 1);
        strobe(1'b0, 0);
        expect_evt(5, 1, 1);
        evt_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            if (evt_valid) begin
                exp_e = exp_q.pop_front();
                got_e = {evt_timestamp, evt_peak, evt_len};
                $display("postrst evt ts=%0d peak=%0d len=%0d", got_e.timestamp, got_e.peak, got_e.len);
                n_cmp++;
                if (got_e !== exp_e) begin n_err++; $display("FAIL postrst_evt got ts=%0d peak=%0d len=%0d need ts=%0d peak=%0d len=%0d", got_e.timestamp, got_e.peak, got_e.len, exp_e.timestamp, exp_e.peak, exp_e.len); end
            end
            @(negedge clk);
        end
        evt_ready = 1'b0;
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL postrst_drain got %0d missing need 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_refractory();
        test_max_len();
        test_fifo_full();
        test_back_to_back();
        test_extremes_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spike_event_framer.md
# spike_event_framer

Downstream stage of the NEO spike detector. It turns the per-sample `spike_in` flag and the matching raw sample stream into discrete spike events: onset timestamp, peak amplitude and duration. It enforces a refractory period after each event and buffers events in a small FIFO behind a valid/ready interface for the readout/segmentation logic.

## Interface
Parameters:
- `TS_W`, default 32: timestamp counter width.
- `ALIGN_DELAY`, default 4: sample-strobe delay applied to `sample_in` so it lines up with `spike_in` (detector latency); 0 allowed.
- `MAX_LEN`, default 64: maximum event length in samples (1..255).
- `REFRACTORY`, default 16: samples ignored after an event closes; 0 allowed.
- `FIFO_DEPTH`, default 8: event FIFO depth; power of two, ≥2.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `sample_valid`, in, 1: strobe qualifying `sample_in` and `spike_in`.
- `sample_in`, in, 16: signed raw sample.
- `spike_in`, in, 1: detector output for this strobe.
- `evt_valid`, out, 1: FIFO head holds an event.
- `evt_ready`, in, 1: consumer accepts the head event.
- `evt_timestamp`, out, TS_W: sample index of the onset.
- `evt_peak`, out, 16: signed aligned sample with the largest magnitude in the event.
- `evt_len`, out, 8: number of samples in the event.
- `drop_cnt`, out, 16: events lost because the FIFO was full; saturates at 0xFFFF.
- `busy`, out, 1: FSM not in IDLE.

## Operation
- All state advances only on `sample_valid`, except FIFO pop.
- `ts_cnt` (TS_W bits) increments per strobe and wraps modulo 2^TS_W. The captured timestamp is the `ts_cnt` value before that strobe's increment.
- Delay line: `aligned` is `sample_in` delayed by ALIGN_DELAY strobes. Its reset contents are 0.
- Magnitude: a 17-bit unsigned absolute value, so −32768 has magnitude 32768. Peak replacement requires strictly greater magnitude, so the first sample wins a tie.
- FSM:
  - IDLE: on strobe with `spike_in`=1, capture ts, peak=aligned, len=1, go to ACTIVE.
  - ACTIVE: on each strobe, update the peak with `aligned`.
    - If `spike_in`=1 and len<MAX_LEN, len++.
    - Otherwise, close the event: the non-spike or overflow strobe's sample still counts for the peak but not for len. Push the event, load refractory count=REFRACTORY, then go to REFRACT, or to IDLE if REFRACTORY=0.
  - REFRACT: on each strobe, decrement. `spike_in` is ignored. The strobe that brings the count to 0 returns to IDLE. Onset is possible on the following strobe.
- Push rule: the push is accepted if FIFO count<FIFO_DEPTH, or if a pop occurs in the same cycle. Otherwise the event is dropped and `drop_cnt` increments with saturation.
- FIFO: first-word-fall-through; `evt_valid` = !empty; pop on `evt_valid && evt_ready`. Outputs are stable while `evt_valid && !evt_ready`.

## Timing
- Reset values:
  - all outputs 0 (`evt_valid`, `evt_timestamp`, `evt_peak`, `evt_len`, `drop_cnt`, `busy`);
  - FSM=IDLE, `ts_cnt`=0, FIFO empty.
- Reset asserted mid-event or mid-refractory discards the partial event and all FIFO contents.
- `busy` is registered: it rises the cycle after the onset strobe.
- Close-to-output latency is 1 clock. The event is written on the closing edge, and `evt_valid` rises on the next cycle if the FIFO was empty.
- Simultaneous pop and push on a full FIFO: both succeed, count stays FIFO_DEPTH, no drop.
- `evt_ready` may be held high permanently: one pop per clock.
- `sample_valid` gaps inside ACTIVE or REFRACT freeze the state and counters.

## Structure
- Package `spike_pkg` contains:
  - FSM state enum {IDLE, ACTIVE, REFRACT};
  - event struct {timestamp, peak, len};
  - SAMPLE_W=16 and LEN_W=8 constants, shared with the NEO detector.
- Sub-module `event_fifo`:
  - synchronous FWFT FIFO parameterised on width and depth;
  - provides count, full and empty;
  - asynchronous active-high reset.
- The framer holds the delay line, timestamp counter and FSM.

## Test plan
- ALIGN_DELAY=0, REFRACTORY=4: `spike_in` high on strobes 10–12 with samples 100, −300, 200 → one event: ts=10, len=3, peak=−300; `evt_valid` rises the clock after strobe 13.
- Spikes on strobes 10–11 and again on 14 with REFRACTORY=4 → one event; strobe 14 is ignored. A spike on strobe 17 opens a new event with ts=17.
- `spike_in` held high for 100 strobes, MAX_LEN=64 → event len=64. After REFRACTORY strobes, a second event opens if `spike_in` is still high.
- `evt_ready`=0, FIFO_DEPTH=8, 10 events → 8 buffered, `drop_cnt`=2. Then `evt_ready`=1 → 8 events popped in order on consecutive clocks.
- FIFO full, and an event closes in the same cycle as a pop → no drop, count stays 8.
- Samples −32768 then 32767 in one event → peak=−32768. Then assert `rst` during ACTIVE → all outputs 0 and no event emitted.
